gem_kchar_tx: RTL

- Transmit-side generator of the GEM optohybrid frame-separator K-character stream, one instance per fiber.
- Drives the 8-bit K-char that the OTMB GEM sync monitor checks: rotation BC→F7→FB→FD→BC, with FE (overflow), 1C (BC0) and 3C (resync) markers substituted in.
- Used in the GEM emulator/loopback path for self-test of the sync monitor.
- Provides error and slip injection so desync detection can be exercised.

---
 rtl/gem_kchar_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gem_kchar_tx.sv
// GEM optohybrid frame-separator K-character generator, one per fiber.
// Sends BC/F7/FB/FD with BC0, overflow and resync markers plus fault injection.
module gem_kchar_tx #(
    parameter int ORBIT_LEN   = 3564,
    parameter int BC0_BX      = 0,
    parameter int RESYNC_HOLD = 16
) (
    input  logic        clock,
    input  logic        global_reset,
    input  logic        enable,
    input  logic        ttc_resync,
    input  logic        overflow,
    input  logic        inject_err,
    input  logic        inject_slip,
    output logic [7:0]  kchar,
    output logic        kchar_valid,
    output logic        bc0_sent,
    output logic        resync_sent,
    output logic        sync_done,
    output logic [11:0] bx_count,
    output logic [15:0] ovf_count
);

    typedef enum logic [1:0] {
        IDLE,
        RESYNC,
        MARK,
        RUN
    } state_t;

    localparam logic [7:0]  HOLD_LD = (RESYNC_HOLD == 0) ? 8'd1 : 8'(RESYNC_HOLD);
    localparam logic [11:0] BX_LAST = 12'(ORBIT_LEN - 1);
    localparam logic [11:0] BX_BC0  = 12'(BC0_BX);

    localparam logic [7:0] K_IDLE = 8'h00;
    localparam logic [7:0] K_BC0  = 8'h1C;
    localparam logic [7:0] K_RSYN = 8'h3C;
    localparam logic [7:0] K_OVF  = 8'hFE;

    state_t      state;
    logic [7:0]  hold;
    logic [1:0]  sep_idx;
    logic        err_pend;
    logic        slip_pend;

    logic [11:0] bx_next;
    logic        in_run;
    logic        err_eff;
    logic        slip_eff;
    logic [7:0]  emit_k;
    logic        emit_bc0;
    logic        emit_ovf;
    logic [1:0]  emit_idx;
    logic        emit_err_pend;
    logic        emit_slip_pend;

    function automatic logic [7:0] sep_char(input logic [1:0] idx);
        logic [7:0] c;
        unique case (idx)
            2'd0:    c = 8'hBC;
            2'd1:    c = 8'hF7;
            2'd2:    c = 8'hFB;
            default: c = 8'hFD;
        endcase
        return c;
    endfunction

    // Character selection for the next RUN cycle (BC0 > FE > error > separator).
    always_comb begin
        bx_next        = (bx_count == BX_LAST) ? 12'd0 : bx_count + 12'd1;
        in_run         = (state == RUN);
        err_eff        = err_pend | (inject_err & in_run);
        slip_eff       = slip_pend | (inject_slip & in_run);
        emit_k         = sep_char(sep_idx);
        emit_bc0       = 1'b0;
        emit_ovf       = 1'b0;
        emit_idx       = sep_idx + 2'd1;
        emit_err_pend  = err_eff;
        emit_slip_pend = slip_eff;
        if (bx_next == BX_BC0) begin
            emit_k   = K_BC0;
            emit_bc0 = 1'b1;
        end else if (overflow) begin
            emit_k   = K_OVF;
            emit_ovf = 1'b1;
        end else begin
            if (err_eff) begin
                emit_k = K_IDLE;
            end
            if (slip_eff) begin
                emit_idx = sep_idx;
            end
            emit_err_pend  = 1'b0;
            emit_slip_pend = 1'b0;
        end
    end

    // Link state machine with registered K-char stream outputs.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            state       <= IDLE;
            hold        <= 8'd0;
            sep_idx     <= 2'd0;
            err_pend    <= 1'b0;
            slip_pend   <= 1'b0;
            kchar       <= K_IDLE;
            kchar_valid <= 1'b0;
            bc0_sent    <= 1'b0;
            resync_sent <= 1'b0;
            sync_done   <= 1'b0;
            bx_count    <= 12'd0;
            ovf_count   <= 16'd0;
        end else begin
            bc0_sent    <= 1'b0;
            resync_sent <= 1'b0;
            if (!enable) begin
                state       <= IDLE;
                sep_idx     <= 2'd0;
                err_pend    <= 1'b0;
                slip_pend   <= 1'b0;
                kchar       <= K_IDLE;
                kchar_valid <= 1'b0;
                sync_done   <= 1'b0;
            end else if (state == IDLE ||
                         (state == RUN && ttc_resync)) begin
                state       <= RESYNC;
                hold        <= HOLD_LD;
                sep_idx     <= 2'd0;
                err_pend    <= 1'b0;
                slip_pend   <= 1'b0;
                kchar       <= K_IDLE;
                kchar_valid <= 1'b0;
                sync_done   <= 1'b0;
            end else if (state == RESYNC) begin
                sep_idx     <= 2'd0;
                kchar_valid <= 1'b0;
                sync_done   <= 1'b0;
                if (ttc_resync) begin
                    hold  <= HOLD_LD;
                    kchar <= K_IDLE;
                end else if (hold <= 8'd1) begin
                    state       <= MARK;
                    hold        <= 8'd0;
                    kchar       <= K_RSYN;
                    kchar_valid <= 1'b1;
                    resync_sent <= 1'b1;
                    bx_count    <= 12'd0;
                    sep_idx     <= 2'd1;
                end else begin
                    hold  <= hold - 8'd1;
                    kchar <= K_IDLE;
                end
            end else begin
                state       <= RUN;
                kchar       <= emit_k;
                kchar_valid <= 1'b1;
                sync_done   <= 1'b1;
                bc0_sent    <= emit_bc0;
                bx_count    <= bx_next;
                sep_idx     <= emit_idx;
                err_pend    <= emit_err_pend;
                slip_pend   <= emit_slip_pend;
                if (emit_ovf && ovf_count != 16'hFFFF) begin
                    ovf_count <= ovf_count + 16'd1;
                end
            end
        end
    end

endmodule
